// File: rtl/vga_draw_pkg.sv
// Shared types and constants for the VGA pixel-write sequencing logic.
// No logic, so there is no latency.
// No handshake, so there is no backpressure.
package vga_draw_pkg;

  localparam int VGA_X_W = 8;
  localparam int VGA_Y_W = 7;
  localparam int VGA_C_W = 3;

  localparam int                 DEF_SCREEN_W  = 160;
  localparam int                 DEF_SCREEN_H  = 120;
  localparam logic [VGA_C_W-1:0] DEF_BG_COLOUR = 3'b000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/vga_scan_counter.sv
// Row-major raster counter over a rectangle: reloads to x0 at row end and flags the final pixel.
// cx/cy update on the edge where load or step is high; vis_nxt is combinational from the next value.
// No handshake: the owner steps it once per cycle while scanning.
module vga_scan_counter
  import vga_draw_pkg::*;
#(
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic       step,
  input  logic [7:0] ld_x,
  input  logic [6:0] ld_y,
  input  logic [7:0] ld_w,
  input  logic [6:0] ld_h,
  output logic [8:0] cx,
  output logic [7:0] cy,
  output logic       last,
  output logic       vis_nxt
);

  localparam logic [8:0] X_LIM = 9'(SCREEN_W);
  localparam logic [7:0] Y_LIM = 8'(SCREEN_H);

  logic [8:0] x_start;
  logic [8:0] x_end;
  logic [7:0] y_end;
  logic [8:0] cx_nxt;
  logic [7:0] cy_nxt;

  always_comb begin
    cx_nxt = cx;
    cy_nxt = cy;
    if (load) begin
      cx_nxt = {1'b0, ld_x};
      cy_nxt = {1'b0, ld_y};
    end else if (step) begin
      if (cx == x_end) begin
        cx_nxt = x_start;
        cy_nxt = cy + 8'd1;
      end else begin
        cx_nxt = cx + 9'd1;
      end
    end
  end

  assign vis_nxt = (cx_nxt < X_LIM) && (cy_nxt < Y_LIM);
  assign last    = (cx == x_end) && (cy == y_end);

  // Bounds are widened by one bit so x0+w-1 and y0+h-1 cannot wrap.
  always_ff @(posedge clock) begin
    if (reset) begin
      cx      <= '0;
      cy      <= '0;
      x_start <= '0;
      x_end   <= '0;
      y_end   <= '0;
    end else begin
      cx <= cx_nxt;
      cy <= cy_nxt;
      if (load) begin
        x_start <= {1'b0, ld_x};
        x_end   <= {1'b0, ld_x} + {1'b0, ld_w} - 9'd1;
        y_end   <= {1'b0, ld_y} + {1'b0, ld_h} - 8'd1;
      end
    end
  end

endmodule

// File: rtl/vga_rect_fill_ctrl.sv
// Rectangle-fill / screen-clear sequencer for the VGA adapter pixel port (abort: VGA_RECT_FILL_ABORT_EN).
// First plot is registered on the handshake edge; w*h scan cycles plus one done cycle.
// cmd_ready is high only in IDLE; the requester holds its command while busy.
module vga_rect_fill_ctrl
  import vga_draw_pkg::*;
#(
  parameter int                 SCREEN_W  = DEF_SCREEN_W,
  parameter int                 SCREEN_H  = DEF_SCREEN_H,
  parameter logic [VGA_C_W-1:0] BG_COLOUR = DEF_BG_COLOUR
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_clear,
  input  logic [7:0] cmd_x,
  input  logic [6:0] cmd_y,
  input  logic [7:0] cmd_w,
  input  logic [6:0] cmd_h,
  input  logic [2:0] cmd_colour,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done
`ifdef VGA_RECT_FILL_ABORT_EN
  ,
  input  logic       abort,
  output logic       aborted
`endif
);

  localparam logic [7:0] CLR_W = 8'(SCREEN_W);
  localparam logic [6:0] CLR_H = 7'(SCREEN_H);

  state_t     state;
  state_t     state_nxt;
  logic       accept;
  logic       empty_rect;
  logic       abort_req;
  logic       step;
  logic [7:0] eff_x;
  logic [6:0] eff_y;
  logic [7:0] eff_w;
  logic [6:0] eff_h;
  logic [2:0] eff_colour;
  logic [8:0] cx;
  logic [7:0] cy;
  logic       last;
  logic       vis_nxt;

`ifdef VGA_RECT_FILL_ABORT_EN
  logic aborted_q;
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign accept     = cmd_valid && (state == IDLE);
  assign eff_x      = cmd_clear ? 8'd0 : cmd_x;
  assign eff_y      = cmd_clear ? 7'd0 : cmd_y;
  assign eff_w      = cmd_clear ? CLR_W : cmd_w;
  assign eff_h      = cmd_clear ? CLR_H : cmd_h;
  assign eff_colour = cmd_clear ? BG_COLOUR : cmd_colour;
  assign empty_rect = (eff_w == 8'd0) || (eff_h == 7'd0);
  assign step       = (state == SCAN) && !last && !abort_req;

  vga_scan_counter #(
    .SCREEN_W(SCREEN_W),
    .SCREEN_H(SCREEN_H)
  ) u_scan (
    .clock  (clock),
    .reset  (reset),
    .load   (accept),
    .step   (step),
    .ld_x   (eff_x),
    .ld_y   (eff_y),
    .ld_w   (eff_w),
    .ld_h   (eff_h),
    .cx     (cx),
    .cy     (cy),
    .last   (last),
    .vis_nxt(vis_nxt)
  );

  assign x = cx[7:0];
  assign y = cy[6:0];

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = empty_rect ? FIN : SCAN;
      SCAN:    if (abort_req || last) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == IDLE);
    busy      = (state != IDLE);
    done      = (state == FIN);
`ifdef VGA_RECT_FILL_ABORT_EN
    aborted   = (state == FIN) && aborted_q;
`endif
  end

  // plot is registered against the counter's next position so it lines up with x/y.
  always_ff @(posedge clock) begin
    if (reset) begin
      plot   <= 1'b0;
      colour <= '0;
    end else begin
      plot <= (state_nxt == SCAN) && vis_nxt;
      if (accept) colour <= eff_colour;
    end
  end

`ifdef VGA_RECT_FILL_ABORT_EN
  always_ff @(posedge clock) begin
    if (reset) aborted_q <= 1'b0;
    else       aborted_q <= (state == SCAN) && abort_req;
  end
`endif

endmodule

// File: tb/tb_vga_rect_fill_ctrl.sv
// Directed vector bench for vga_rect_fill_ctrl: table of commands plus hand-written corner sequences.
module tb_vga_rect_fill_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_clear;
  logic [7:0] cmd_x;
  logic [6:0] cmd_y;
  logic [7:0] cmd_w;
  logic [6:0] cmd_h;
  logic [2:0] cmd_colour;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       done;
`ifdef VGA_RECT_FILL_ABORT_EN
  logic       abort;
  logic       aborted;
`endif

  int checks = 0;
  int errors = 0;

  vga_rect_fill_ctrl dut (
    .clock     (clock),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_clear (cmd_clear),
    .cmd_x     (cmd_x),
    .cmd_y     (cmd_y),
    .cmd_w     (cmd_w),
    .cmd_h     (cmd_h),
    .cmd_colour(cmd_colour),
    .x         (x),
    .y         (y),
    .colour    (colour),
    .plot      (plot),
    .busy      (busy),
    .done      (done)
`ifdef VGA_RECT_FILL_ABORT_EN
    ,
    .abort     (abort),
    .aborted   (aborted)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    string      name;
    logic       clr;
    logic [7:0] vx;
    logic [6:0] vy;
    logic [7:0] vw;
    logic [6:0] vh;
    logic [2:0] vcol;
    int         exp_plots;
    int         exp_done;
    logic [2:0] exp_col;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_cmd(input logic clr, input logic [7:0] vx, input logic [6:0] vy,
                         input logic [7:0] vw, input logic [6:0] vh, input logic [2:0] vcol);
    cmd_clear  = clr;
    cmd_x      = vx;
    cmd_y      = vy;
    cmd_w      = vw;
    cmd_h      = vh;
    cmd_colour = vcol;
  endtask

  // Issues one command and walks every cycle through one past the done pulse,
  // comparing against a raster model with clipping.
  task automatic run_vec(input vec_t v);
    int x0, y0, w, h, wh, k, ex, ey;
    int n_plots, done_cnt, done_cyc, mism, bmism;
    logic exp_p, exp_busy;
    x0 = v.clr ? 0 : int'(v.vx);
    y0 = v.clr ? 0 : int'(v.vy);
    w  = v.clr ? 160 : int'(v.vw);
    h  = v.clr ? 120 : int'(v.vh);
    wh = w * h;
    n_plots = 0; done_cnt = 0; done_cyc = -1; mism = 0; bmism = 0;
    set_cmd(v.clr, v.vx, v.vy, v.vw, v.vh, v.vcol);
    cmd_valid = 1'b1;
    chk({v.name, " ready_before"}, int'(cmd_ready), 1);
    tick();
    cmd_valid = 1'b0;
    for (int c = 1; c <= v.exp_done + 1; c++) begin
      k = c - 1;
      exp_p = 1'b0;
      ex = 0;
      ey = 0;
      if (c <= wh) begin
        ex = x0 + (k % w);
        ey = y0 + (k / w);
        exp_p = (ex < 160) && (ey < 120);
      end
      if (plot !== exp_p) begin
        if (mism == 0) $display("FAIL %s plot at cycle %0d: got %0b, expected %0b", v.name, c, plot, exp_p);
        mism++;
      end else if (exp_p && (x !== ex[7:0] || y !== ey[6:0] || colour !== v.exp_col)) begin
        if (mism == 0) $display("FAIL %s pixel at cycle %0d: got (%0d,%0d,%0d), expected (%0d,%0d,%0d)",
                                v.name, c, x, y, colour, ex, ey, v.exp_col);
        mism++;
      end
      if (plot === 1'b1) n_plots++;
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = c;
      end
      exp_busy = (c <= wh + 1);
      if (busy !== exp_busy || cmd_ready !== !exp_busy) bmism++;
      if (c <= v.exp_done) tick();
    end
    chk({v.name, " pixel_mismatches"}, mism, 0);
    chk({v.name, " plots"}, n_plots, v.exp_plots);
    chk({v.name, " done_cycle"}, done_cyc, v.exp_done);
    chk({v.name, " done_pulses"}, done_cnt, 1);
    chk({v.name, " busy_ready_mismatches"}, bmism, 0);
    chk({v.name, " ready_after"}, int'(cmd_ready), 1);
  endtask

  initial begin
    int np, nd;
    vecs[0] = '{"rect10_20",  1'b0, 8'd10,  7'd20,  8'd3,   7'd2, 3'b101, 6,     7,     3'b101};
    vecs[1] = '{"clear",      1'b1, 8'd5,   7'd9,   8'd0,   7'd0, 3'b111, 19200, 19201, 3'b000};
    vecs[2] = '{"corner_clip",1'b0, 8'd158, 7'd118, 8'd4,   7'd4, 3'b010, 4,     17,    3'b010};
    vecs[3] = '{"w0_h5",      1'b0, 8'd5,   7'd5,   8'd0,   7'd5, 3'b011, 0,     1,     3'b011};
    vecs[4] = '{"w5_h0",      1'b0, 8'd5,   7'd5,   8'd5,   7'd0, 3'b011, 0,     1,     3'b011};
    vecs[5] = '{"single",     1'b0, 8'd0,   7'd0,   8'd1,   7'd1, 3'b111, 1,     2,     3'b111};
    vecs[6] = '{"all_offscr", 1'b0, 8'd200, 7'd0,   8'd255, 7'd1, 3'b001, 0,     256,   3'b001};
    vecs[7] = '{"bottom_row", 1'b0, 8'd150, 7'd119, 8'd20,  7'd3, 3'b110, 10,    61,    3'b110};
    vecs[8] = '{"rect_again", 1'b0, 8'd1,   7'd2,   8'd2,   7'd3, 3'b100, 6,     7,     3'b100};

    reset = 1'b1;
    cmd_valid = 1'b0;
    set_cmd(1'b0, 8'd0, 7'd0, 8'd0, 7'd0, 3'd0);
`ifdef VGA_RECT_FILL_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) tick();
    chk("plot_in_reset", int'(plot), 0);
    reset = 1'b0;
    chk("rst_plot", int'(plot), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_ready", int'(cmd_ready), 1);
    chk("rst_xyc", int'({x, y, colour}), 0);
    np = 0;
    repeat (5) begin
      tick();
      if (plot === 1'b1 || done === 1'b1) np++;
    end
    chk("idle_no_activity", np, 0);

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Second command held valid while busy: accepted only once back in IDLE.
    set_cmd(1'b0, 8'd0, 7'd0, 8'd2, 7'd2, 3'b001);
    cmd_valid = 1'b1;
    tick();
    set_cmd(1'b0, 8'd50, 7'd50, 8'd1, 7'd1, 3'b100);
    chk("hold_c1_pix", int'({plot, x, y, colour}), int'({1'b1, 8'd0, 7'd0, 3'b001}));
    chk("hold_c1_ready", int'(cmd_ready), 0);
    tick(); tick(); tick();
    chk("hold_c4_pix", int'({plot, x, y, colour}), int'({1'b1, 8'd1, 7'd1, 3'b001}));
    tick();
    chk("hold_c5_fin", int'({done, cmd_ready, plot}), int'(3'b100));
    tick();
    chk("hold_c6_idle", int'({done, cmd_ready, plot}), int'(3'b010));
    tick();
    cmd_valid = 1'b0;
    chk("hold_c7_second", int'({plot, x, y, colour, busy}), int'({1'b1, 8'd50, 7'd50, 3'b100, 1'b1}));
    tick();
    chk("hold_c8_done", int'(done), 1);
    tick();

    // Reset during the third pixel of a 5x5 fill.
    set_cmd(1'b0, 8'd30, 7'd40, 8'd5, 7'd5, 3'b010);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick(); tick();
    chk("mid_c3_x", int'({plot, x}), int'({1'b1, 8'd32}));
    reset = 1'b1;
    tick();
    chk("mid_rst_plot", int'({plot, done, busy}), 0);
    reset = 1'b0;
    chk("mid_rel_ready", int'(cmd_ready), 1);
    np = 0; nd = 0;
    repeat (30) begin
      tick();
      if (plot === 1'b1) np++;
      if (done === 1'b1) nd++;
    end
    chk("mid_no_plot", np, 0);
    chk("mid_no_done", nd, 0);

`ifdef VGA_RECT_FILL_ABORT_EN
    abort = 1'b1;
    tick();
    chk("abort_idle_noeffect", int'({cmd_ready, done, aborted}), int'(3'b100));
    abort = 1'b0;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick(); tick();
    chk("abort_c3_x", int'({plot, x}), int'({1'b1, 8'd32}));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_fin", int'({plot, done, aborted, busy}), int'(4'b0111));
    tick();
    chk("abort_idle", int'({done, aborted, cmd_ready}), int'(3'b001));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_rect_fill_ctrl.md
Name: vga_rect_fill_ctrl

Overview:
- Sequences the VGA adapter's pixel-write port (x[7:0], y[6:0], colour[2:0], plot) at 160x120 resolution.
- Accepts one command at a time: either fill a rectangle in one colour, or clear the whole screen.
- Emits exactly one registered plot per cycle, scanning row-major.
- Sits between the game/draw logic and the VGA adapter.

Parameters:
- SCREEN_W, 160, visible width in pixels; x >= SCREEN_W is off-screen.
- SCREEN_H, 120, visible height in pixels; y >= SCREEN_H is off-screen.
- BG_COLOUR, 3'b000, colour used by the clear command.

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command (high only in IDLE).
- cmd_clear  in  1  1 = clear screen (cmd_x/y/w/h/colour ignored); 0 = rectangle fill.
- cmd_x  in  8  rectangle left column.
- cmd_y  in  7  rectangle top row.
- cmd_w  in  8  rectangle width in pixels.
- cmd_h  in  7  rectangle height in pixels.
- cmd_colour  in  3  fill colour.
- x  out  8  pixel column to adapter.
- y  out  7  pixel row to adapter.
- colour  out  3  pixel colour to adapter.
- plot  out  1  write strobe to adapter.
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse after the last pixel slot of a command.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; x=0, y=0, colour=0; plot=0, busy=0, done=0; cmd_ready=1 on the first cycle after reset deasserts.
- Reset asserted mid-command: the command is abandoned. plot goes 0 on the next edge. No done pulse.
- States:
  - IDLE: cmd_ready=1, busy=0. On cmd_valid&&cmd_ready, latch the command and go to SCAN. If w==0 or h==0 (rectangle only), go to FIN instead.
  - SCAN: busy=1, cmd_ready=0. Each cycle output the current (cx,cy) with plot=1 if on-screen, otherwise plot=0.
    - Advance cx.
    - When cx reaches x0+w-1: set cx=x0 and advance cy.
    - When the final pixel (x0+w-1, y0+h-1) has been output, go to FIN.
  - FIN: done=1 for one cycle, plot=0, busy=1. Next state is IDLE.
- Clear command: x0=0, y0=0, w=SCREEN_W, h=SCREEN_H, colour=BG_COLOUR.
- Latency: handshake in cycle N; first plot registered at edge N+1. A w×h command occupies w*h SCAN cycles plus 1 FIN cycle.
- Full clear takes 19200+1 cycles.
- Arithmetic: internal cx is 9 bits and cy is 8 bits so x0+w and y0+h never wrap.
- Clipping: pixels with cx>=SCREEN_W or cy>=SCREEN_H are not plotted, but still consume their cycle. Timing is therefore data-independent.
- x/y outputs carry cx[7:0]/cy[6:0].
- cmd_valid while busy is ignored. cmd_ready stays low and the requester holds the command.
- Simultaneous FIN and cmd_valid: not accepted until IDLE, one cycle later.
- Outputs hold their last values when plot=0. The adapter ignores them.

Optional Feature:
- Macro: VGA_RECT_FILL_ABORT_EN.
- With the macro defined: adds input port abort (1 bit).
  - abort=1 in SCAN forces plot=0 at the next edge and moves to FIN. done still pulses, and an output aborted (1 bit) is high during that FIN cycle.
  - abort in IDLE or FIN has no effect.
- Without the macro: neither port exists, and every command runs to completion.

Decomposition:
- Package vga_draw_pkg holds:
  - state enum {IDLE, SCAN, FIN};
  - constants VGA_X_W=8, VGA_Y_W=7, VGA_C_W=3;
  - default SCREEN_W/SCREEN_H/BG_COLOUR values.
- Sub-module vga_scan_counter holds the raster cx/cy counter with x0 reload, row advance and last-pixel flag, controlled by load/step inputs. The top-level FSM, handshake and clipping stay in vga_rect_fill_ctrl.

Test Plan:
- Reset held 3 cycles, then released → plot=0, busy=0, done=0, cmd_ready=1. No plot ever occurs without a command.
- Rectangle x=10,y=20,w=3,h=2,colour=3'b101 → six plots in consecutive cycles: (10,20),(11,20),(12,20),(10,21),(11,21),(12,21). Then one done pulse; cmd_ready=1 on the next cycle.
- Clear command → exactly 19200 plots, colour=BG_COLOUR, covering (0,0)..(159,119) row-major. done on cycle 19201 after the handshake.
- Rectangle x=158,y=118,w=4,h=4 → plots only at (158,118),(159,118),(158,119),(159,119). 16 SCAN cycles before done.
- Rectangle w=0,h=5 → zero plots; done pulses on the cycle after the handshake. A second command issued while busy is not accepted until IDLE.
- Reset asserted during the 3rd pixel of a 5×5 fill → plot=0 the next cycle, no done, cmd_ready=1 after release. If VGA_RECT_FILL_ABORT_EN is defined, repeat with abort instead → done and aborted both high for one cycle.
